imem_load_ctrl: RTL and testbench
=================================

Name: imem_load_ctrl

Overview:
- Owns the instruction RAM port and sequences the fetch stage around it.
- Arbitrates that port between the core fetch path (RUN) and an external program loader (LOAD).
- Holds the core in reset, with fetch disabled and IF/ID flushed, while a program is written.
- Releases the core from a clean flush window so fetch restarts from PC 0.

Parameters:
- ADDR_WIDTH, 16, byte address width of the instruction RAM port.
- DATA_WIDTH, 32, instruction word width.
- FLUSH_CYCLES, 2, cycles core_rst stays high in FLUSH before RUN (legal range 1..15).
- AUTO_RUN, 0, when 1 the block leaves reset via FLUSH into RUN without a run_req.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_start  in  1  pulse: enter LOAD.
- ld_done  in  1  pulse: loading finished; go to FLUSH.
- run_req  in  1  pulse: in HALT, start the core without loading.
- ld_req_valid  in  1  loader write beat valid.
- ld_req_ready  out  1  loader beat accepted this cycle.
- ld_addr  in  ADDR_WIDTH  loader byte address.
- ld_data  in  DATA_WIDTH  loader instruction word.
- fetch_pc  in  ADDR_WIDTH  fetch stage PC, low bits.
- core_rst  out  1  reset to the core and PC register.
- fetch_pc_en  out  1  drives fetch pc_en.
- fetch_flush  out  1  drives fetch flash_if_id.
- imem_en  out  1  RAM enable.
- imem_we  out  1  RAM write enable.
- imem_addr  out  ADDR_WIDTH  RAM byte address.
- imem_din  out  DATA_WIDTH  RAM write data.
- busy  out  1  state != RUN.
- wr_count  out  16  words successfully written since the last ld_start.
- err_misaligned  out  1  sticky: a beat with ld_addr[1:0] != 0 was seen.

Behaviour:
- States: HALT, LOAD, FLUSH, RUN. Encodings are in the shared package.
- Reset, highest priority, any state:
  - state = HALT, or FLUSH when AUTO_RUN = 1.
  - flush counter = 0, wr_count = 0, err_misaligned = 0.
  - Resulting outputs: core_rst = 1, fetch_pc_en = 0, fetch_flush = 1, imem_en = 0, imem_we = 0, ld_req_ready = 0, busy = 1.
- HALT:
  - Outputs: core_rst = 1, fetch_pc_en = 0, fetch_flush = 1, imem_en = 0.
  - Transitions: ld_start -> LOAD; else run_req -> FLUSH. ld_start has priority over run_req.
  - Entering LOAD clears wr_count and err_misaligned on the transition edge.
- LOAD:
  - Core held as in HALT.
  - ld_req_ready = 1, combinational from state only; never depends on ld_req_valid.
  - Accepted beat = ld_req_valid & ld_req_ready. On an accepted beat in the same cycle: imem_en = 1, imem_addr = ld_addr, imem_din = ld_data.
  - imem_we = 1 only if ld_addr[1:0] == 0. A misaligned beat is consumed with no write and sets err_misaligned.
  - Each successful write increments wr_count, saturating at 16'hFFFF.
  - ld_done -> FLUSH. A beat accepted in the ld_done cycle is still written.
  - ld_start in LOAD is ignored; it wins over nothing.
- FLUSH:
  - core_rst = 1, fetch_flush = 1, fetch_pc_en = 0, imem_en = 0, ld_req_ready = 0.
  - The counter counts 0..FLUSH_CYCLES-1, then -> RUN. FLUSH lasts exactly FLUSH_CYCLES cycles.
  - ld_start in FLUSH -> LOAD and aborts the release.
- RUN:
  - core_rst = 0, fetch_pc_en = 1, fetch_flush = 0, imem_en = 1, imem_we = 0, imem_addr = fetch_pc, ld_req_ready = 0.
  - ld_start -> LOAD. The next cycle core_rst = 1 and fetch_flush = 1, so no partially fetched instruction survives.
  - run_req and ld_done are ignored in RUN.
- Output timing:
  - core_rst, fetch_pc_en, fetch_flush and busy are Moore, decoded from the state register. Zero combinational paths from inputs.
  - imem_* are combinational muxes selected by state; the loader path is Mealy on ld_req_valid.
- Outside LOAD: imem_din = 0, and ld_req_valid is ignored with no count or error change.

Decomposition:
- Shared package (defines include):
  - state encodings IMEM_ST_HALT/LOAD/FLUSH/RUN (2 bits);
  - WR_COUNT_WIDTH = 16;
  - the reset PC constant (32'h0).
- No sub-module; one FSM plus two counters.
- The RAM mux stays inside the block. The fetch stage consumes fetch_pc_en, fetch_flush and core_rst unchanged.

Test Plan:
- Reset, AUTO_RUN = 0: rst high 3 cycles then low, no other stimulus -> busy = 1, core_rst = 1, fetch_flush = 1, wr_count = 0, imem_en = 0 held indefinitely.
- Load and release: ld_start, then 4 aligned beats at addr 0x0/0x4/0x8/0xC (data 0x00000013 ... 0x00000073), then ld_done:
  - imem_we high on exactly 4 cycles, with matching addr and data; wr_count = 4.
  - FLUSH lasts 2 cycles, then core_rst = 0, fetch_pc_en = 1, imem_addr tracks fetch_pc.
- Misaligned beat: during LOAD, beat at addr 0x6 -> imem_we = 0 that cycle, err_misaligned = 1 (sticky), wr_count unchanged. A following beat at 0x8 writes normally.
- Simultaneous beat and ld_done: beat at 0x10 in the same cycle as ld_done -> write occurs, wr_count increments, next state FLUSH.
- Reload from RUN: ld_start while RUN -> next cycle core_rst = 1, fetch_flush = 1, fetch_pc_en = 0, wr_count = 0, err_misaligned cleared.
- Reset mid-LOAD: rst asserted after 2 beats -> next cycle HALT, wr_count = 0, ld_req_ready = 0. A later run_req reaches RUN after FLUSH_CYCLES cycles.

Source files
------------

// File: rtl/imem_load_ctrl_pkg.sv
// Shared definitions for the instruction-memory load controller:
// FSM state encodings, write counter width and the core's reset PC.
package imem_load_ctrl_pkg;

   typedef enum logic [1:0] {
      IMEM_ST_HALT  = 2'd0,
      IMEM_ST_LOAD  = 2'd1,
      IMEM_ST_FLUSH = 2'd2,
      IMEM_ST_RUN   = 2'd3
   } imem_state_t;

   localparam int          WR_COUNT_WIDTH = 16;
   localparam logic [31:0] RESET_PC       = 32'h0;

endpackage

// File: rtl/imem_load_ctrl.sv
// Instruction RAM port owner. Arbitrates the RAM between the program loader
// (LOAD) and the core fetch path (RUN), and holds the core in reset with
// IF/ID flushed until a clean release through the FLUSH window.
module imem_load_ctrl
   import imem_load_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int AUTO_RUN     = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ld_start,
   input  logic                      ld_done,
   input  logic                      run_req,
   input  logic                      ld_req_valid,
   output logic                      ld_req_ready,
   input  logic [ADDR_WIDTH-1:0]     ld_addr,
   input  logic [DATA_WIDTH-1:0]     ld_data,
   input  logic [ADDR_WIDTH-1:0]     fetch_pc,
   output logic                      core_rst,
   output logic                      fetch_pc_en,
   output logic                      fetch_flush,
   output logic                      imem_en,
   output logic                      imem_we,
   output logic [ADDR_WIDTH-1:0]     imem_addr,
   output logic [DATA_WIDTH-1:0]     imem_din,
   output logic                      busy,
   output logic [WR_COUNT_WIDTH-1:0] wr_count,
   output logic                      err_misaligned
);

   localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
   localparam imem_state_t RST_STATE = (AUTO_RUN != 0) ? IMEM_ST_FLUSH : IMEM_ST_HALT;
   localparam logic [WR_COUNT_WIDTH-1:0] WR_COUNT_MAX = '1;

   imem_state_t               state_reg;
   logic [3:0]                flush_cnt_reg;
   logic [WR_COUNT_WIDTH-1:0] wr_count_reg;
   logic                      err_reg;

   logic load_active;
   logic beat;
   logic beat_aligned;

   // Loader handshake: ready depends on state only, so a beat is valid & LOAD.
   always_comb begin
      load_active  = (state_reg == IMEM_ST_LOAD);
      beat         = ld_req_valid & load_active;
      beat_aligned = (ld_addr[1:0] == 2'b00);
   end

   // Main FSM plus the flush-window counter and loader write statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= RST_STATE;
         flush_cnt_reg <= '0;
         wr_count_reg  <= '0;
         err_reg       <= 1'b0;
      end else begin
         case (state_reg)
            IMEM_ST_HALT: begin
               if (ld_start) begin
                  state_reg    <= IMEM_ST_LOAD;
                  wr_count_reg <= '0;
                  err_reg      <= 1'b0;
               end else if (run_req) begin
                  state_reg     <= IMEM_ST_FLUSH;
                  flush_cnt_reg <= '0;
               end
            end
            IMEM_ST_LOAD: begin
               // A beat in the ld_done cycle is still written and counted.
               if (beat && beat_aligned && (wr_count_reg != WR_COUNT_MAX)) begin
                  wr_count_reg <= wr_count_reg + 1'b1;
               end
               if (beat && !beat_aligned) begin
                  err_reg <= 1'b1;
               end
               if (ld_done) begin
                  state_reg     <= IMEM_ST_FLUSH;
                  flush_cnt_reg <= '0;
               end
            end
            IMEM_ST_FLUSH: begin
               if (ld_start) begin
                  state_reg     <= IMEM_ST_LOAD;
                  flush_cnt_reg <= '0;
                  wr_count_reg  <= '0;
                  err_reg       <= 1'b0;
               end else if (flush_cnt_reg == FLUSH_LAST) begin
                  state_reg     <= IMEM_ST_RUN;
                  flush_cnt_reg <= '0;
               end else begin
                  flush_cnt_reg <= flush_cnt_reg + 1'b1;
               end
            end
            IMEM_ST_RUN: begin
               // Reload drops straight back into reset so no fetch survives.
               if (ld_start) begin
                  state_reg    <= IMEM_ST_LOAD;
                  wr_count_reg <= '0;
                  err_reg      <= 1'b0;
               end
            end
            default: begin
               state_reg     <= IMEM_ST_HALT;
               flush_cnt_reg <= '0;
            end
         endcase
      end
   end

   // Core control is decoded from the state register only.
   always_comb begin
      core_rst     = (state_reg != IMEM_ST_RUN);
      fetch_pc_en  = (state_reg == IMEM_ST_RUN);
      fetch_flush  = (state_reg != IMEM_ST_RUN);
      busy         = (state_reg != IMEM_ST_RUN);
      ld_req_ready = load_active;
   end

   // RAM port mux: loader path in LOAD, fetch path in RUN, idle otherwise.
   always_comb begin
      imem_en   = 1'b0;
      imem_we   = 1'b0;
      imem_addr = RESET_PC[ADDR_WIDTH-1:0];
      imem_din  = '0;
      case (state_reg)
         IMEM_ST_LOAD: begin
            imem_en   = beat;
            imem_we   = beat & beat_aligned;
            imem_addr = ld_addr;
            imem_din  = ld_data;
         end
         IMEM_ST_RUN: begin
            imem_en   = 1'b1;
            imem_addr = fetch_pc;
         end
         default: begin
         end
      endcase
   end

   assign wr_count       = wr_count_reg;
   assign err_misaligned = err_reg;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl with a write scoreboard on the RAM port.
module tb_imem_load_ctrl;

   localparam int AW = 16;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          ld_start, ld_done, run_req, ld_req_valid;
   logic          ld_req_ready;
   logic [AW-1:0] ld_addr, fetch_pc;
   logic [DW-1:0] ld_data;
   logic          core_rst, fetch_pc_en, fetch_flush, imem_en, imem_we;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_din;
   logic          busy;
   logic [15:0]   wr_count;
   logic          err_misaligned;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t sb_q[$];
   int  total = 0;
   int  bad = 0;
   int  we_cycles = 0;
   int  flush_len;

   always #5 clk = ~clk;

   imem_load_ctrl #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FLUSH_CYCLES(2), .AUTO_RUN(0)
   ) dut (
      .clk(clk), .rst(rst), .ld_start(ld_start), .ld_done(ld_done),
      .run_req(run_req), .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
      .ld_addr(ld_addr), .ld_data(ld_data), .fetch_pc(fetch_pc),
      .core_rst(core_rst), .fetch_pc_en(fetch_pc_en), .fetch_flush(fetch_flush),
      .imem_en(imem_en), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_din(imem_din), .busy(busy), .wr_count(wr_count),
      .err_misaligned(err_misaligned)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Sample point away from the active edge; scoreboard every RAM write.
   task automatic half();
      wr_t e;
      @(negedge clk);
      if (imem_we === 1'b1) begin
         we_cycles++;
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_we", 32'(imem_we), 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("sb_addr", 32'(imem_addr), 32'(e.a));
            chk("sb_data", imem_din, e.d);
            $display("write addr=%h data=%h", imem_addr, imem_din);
         end
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      sb_q.push_back(e);
   endtask

   task automatic chk_held(input string tag);
      chk({tag, "_core_rst"}, 32'(core_rst), 32'd1);
      chk({tag, "_flush"}, 32'(fetch_flush), 32'd1);
      chk({tag, "_pc_en"}, 32'(fetch_pc_en), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
   endtask

   initial begin
      logic [DW-1:0] prog [4];
      prog[0] = 32'h00000013; prog[1] = 32'h00000033;
      prog[2] = 32'h00000053; prog[3] = 32'h00000073;

      rst = 1'b1; ld_start = 1'b0; ld_done = 1'b0; run_req = 1'b0;
      ld_req_valid = 1'b0; ld_addr = '0; ld_data = '0; fetch_pc = 16'h0020;

      // Reset held for 3 cycles, then idle in HALT.
      for (int i = 0; i < 3; i++) begin
         adv();
         half();
         chk_held("rst");
         chk("rst_imem_en", 32'(imem_en), 32'd0);
         chk("rst_ready", 32'(ld_req_ready), 32'd0);
      end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         adv();
         half();
         chk_held("halt");
         chk("halt_imem_en", 32'(imem_en), 32'd0);
         chk("halt_wr_count", 32'(wr_count), 32'd0);
      end
      adv();

      // Load four aligned words, then release.
      ld_start = 1'b1; half(); adv(); ld_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ld_req_valid = 1'b1; ld_addr = 16'(i * 4); ld_data = prog[i];
         push_wr(ld_addr, ld_data);
         half();
         chk("load_ready", 32'(ld_req_ready), 32'd1);
         chk("load_we", 32'(imem_we), 32'd1);
         chk_held("load");
         adv();
      end
      ld_req_valid = 1'b0;
      half();
      chk("load_wr_count", 32'(wr_count), 32'd4);
      chk("load_we_cycles", 32'(we_cycles), 32'd4);
      chk("load_idle_en", 32'(imem_en), 32'd0);
      adv();
      ld_done = 1'b1; half(); adv(); ld_done = 1'b0;
      half();
      chk_held("flush1");
      chk("flush1_ready", 32'(ld_req_ready), 32'd0);
      chk("flush1_imem_en", 32'(imem_en), 32'd0);
      adv(); half();
      chk_held("flush2");
      adv(); half();
      chk("run_core_rst", 32'(core_rst), 32'd0);
      chk("run_pc_en", 32'(fetch_pc_en), 32'd1);
      chk("run_flush", 32'(fetch_flush), 32'd0);
      chk("run_busy", 32'(busy), 32'd0);
      chk("run_imem_en", 32'(imem_en), 32'd1);
      chk("run_imem_addr", 32'(imem_addr), 32'h20);
      adv();
      fetch_pc = 16'h0024;
      ld_req_valid = 1'b1; ld_addr = 16'h0002; ld_data = 32'hDEADBEEF;
      half();
      chk("run_track_pc", 32'(imem_addr), 32'h24);
      chk("run_ignore_we", 32'(imem_we), 32'd0);
      chk("run_din_zero", imem_din, 32'd0);
      chk("run_ready", 32'(ld_req_ready), 32'd0);
      adv();
      ld_req_valid = 1'b0;
      half();
      chk("run_cnt_kept", 32'(wr_count), 32'd4);
      chk("run_err_kept", 32'(err_misaligned), 32'd0);
      adv();

      // Reload from RUN, misaligned beat, beat coincident with ld_done.
      ld_start = 1'b1; half(); adv(); ld_start = 1'b0;
      half();
      chk_held("reload");
      chk("reload_wr_count", 32'(wr_count), 32'd0);
      adv();
      ld_req_valid = 1'b1; ld_addr = 16'h0006; ld_data = 32'h11111111;
      half();
      chk("mis_we", 32'(imem_we), 32'd0);
      chk("mis_en", 32'(imem_en), 32'd1);
      adv();
      ld_addr = 16'h0008; ld_data = 32'h22222222; push_wr(ld_addr, ld_data);
      half();
      chk("mis_err", 32'(err_misaligned), 32'd1);
      chk("mis_wr_count", 32'(wr_count), 32'd0);
      chk("after_mis_we", 32'(imem_we), 32'd1);
      adv();
      ld_addr = 16'h0010; ld_data = 32'h33333333; ld_done = 1'b1;
      push_wr(ld_addr, ld_data);
      half();
      chk("done_beat_we", 32'(imem_we), 32'd1);
      chk("done_beat_cnt", 32'(wr_count), 32'd1);
      adv();
      ld_req_valid = 1'b0; ld_done = 1'b0;
      half();
      chk("done_wr_count", 32'(wr_count), 32'd2);
      chk("done_err_sticky", 32'(err_misaligned), 32'd1);
      chk("done_ready", 32'(ld_req_ready), 32'd0);
      chk_held("done_flush");
      adv(); half(); adv(); half();
      chk("rerun_busy", 32'(busy), 32'd0);
      adv();
      ld_start = 1'b1; half(); adv(); ld_start = 1'b0;
      half();
      chk("reload2_err", 32'(err_misaligned), 32'd0);
      chk("reload2_cnt", 32'(wr_count), 32'd0);
      chk_held("reload2");
      adv();

      // Reset in the middle of a load, then release via run_req.
      for (int i = 0; i < 2; i++) begin
         ld_req_valid = 1'b1; ld_addr = 16'(i * 4); ld_data = prog[i];
         push_wr(ld_addr, ld_data);
         half(); adv();
      end
      ld_req_valid = 1'b0; rst = 1'b1;
      half();
      chk("pre_rst_cnt", 32'(wr_count), 32'd2);
      adv();
      rst = 1'b0;
      half();
      chk_held("midrst");
      chk("midrst_ready", 32'(ld_req_ready), 32'd0);
      chk("midrst_cnt", 32'(wr_count), 32'd0);
      adv();
      run_req = 1'b1; half(); adv(); run_req = 1'b0;
      flush_len = 0;
      for (int i = 0; i < 20; i++) begin
         half();
         if (core_rst !== 1'b1) break;
         flush_len++;
         adv();
      end
      chk("runreq_flush_len", 32'(flush_len), 32'd2);
      chk("runreq_core_rst", 32'(core_rst), 32'd0);
      adv();

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      chk("total_we_cycles", 32'(we_cycles), 32'd8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
